fuzzy_mc_engine: RTL

FUZZY_MC_ENGINE -- requirements
Module: fuzzy_mc_engine

---
 rtl/fuzzy_pkg.sv | 42 ++++
 rtl/fuzzy_div_seq.sv | 77 +++++++
 rtl/fuzzy_mc_engine.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fuzzy_pkg.sv
`default_nettype none
// ============================================================================
// fuzzy_pkg : shared types and constants for the fuzzy Mamdani/singleton engine
// Rev 1.0
// ============================================================================
package fuzzy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DIV  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  typedef enum logic {
    AND_MIN  = 1'b0,
    AND_PROD = 1'b1
  } and_mode_e;

  localparam logic [1:0] NEG  = 2'd0;
  localparam logic [1:0] ZERO = 2'd1;
  localparam logic [1:0] POS  = 2'd2;

  localparam int N_RULES = 9;

  // Rule r = 3*i + j: recover the T term i and the dT term j.
  function automatic logic [1:0] rule_t_term(input logic [3:0] r);
    if (r >= 4'd6)      return POS;
    else if (r >= 4'd3) return ZERO;
    else                return NEG;
  endfunction

  function automatic logic [1:0] rule_d_term(input logic [3:0] r);
    logic [3:0] rem;
    if (r >= 4'd6)      rem = r - 4'd6;
    else if (r >= 4'd3) rem = r - 4'd3;
    else                rem = r;
    return rem[1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/fuzzy_div_seq.sv
`default_nettype none
// ============================================================================
// fuzzy_div_seq : restoring divider, one quotient bit per cycle, zero flag
// Rev 1.0
// ============================================================================
module fuzzy_div_seq #(
  parameter int NW = 20,
  parameter int DW = 12,
  parameter int QW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_i,
  input  logic [NW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          done_o,
  output logic [QW-1:0] quot_o,
  output logic          zero_o
);

  localparam int CNTW = $clog2(QW + 1);

  logic [DW-1:0]   rem_q, dsr_q;
  logic [QW-1:0]   dvd_q, quot_q;
  logic [CNTW-1:0] cnt_q;
  logic            run_q, done_q, zero_q;

  logic [DW:0] trial, diff;
  logic        fit;

  always_comb begin
    trial = {rem_q, dvd_q[QW-1]};
    diff  = trial - {1'b0, dsr_q};
    fit   = (trial >= {1'b0, dsr_q});
  end

  // The quotient fits in QW bits, so the dividend's upper bits are already
  // a valid partial remainder and only QW steps are needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_q  <= '0;
      dsr_q  <= '0;
      dvd_q  <= '0;
      quot_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        rem_q  <= DW'(dividend_i >> QW);
        dvd_q  <= dividend_i[QW-1:0];
        dsr_q  <= divisor_i;
        quot_q <= '0;
        cnt_q  <= CNTW'(QW);
        run_q  <= 1'b1;
        zero_q <= (divisor_i == '0);
      end else if (run_q) begin
        rem_q  <= fit ? DW'(diff) : DW'(trial);
        quot_q <= (quot_q << 1) | QW'(fit);
        dvd_q  <= dvd_q << 1;
        cnt_q  <= cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign quot_o = zero_q ? '0 : quot_q;
  assign zero_o = zero_q;

endmodule
`default_nettype wire

// File: rtl/fuzzy_mc_engine.sv
`default_nettype none
// ============================================================================
// fuzzy_mc_engine : 3x3-rule fuzzy controller, weighted-singleton defuzzifier
// Rev 1.0
// ============================================================================
module fuzzy_mc_engine
  import fuzzy_pkg::*;
#(
  parameter  int N_CH = 4,
  parameter  int MW   = 8,
  parameter  int GW   = 8,
  localparam int CW   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CW-1:0]          in_ch,
  input  logic [3*MW-1:0]        in_muT,
  input  logic [3*MW-1:0]        in_muD,
  input  logic                   in_mode,
  input  logic [N_CH*9*GW-1:0]   g_tab,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CW-1:0]          out_ch,
  output logic [GW-1:0]          out_g,
  output logic                   out_nofire,
  output logic                   out_err,
  output logic                   busy
);

  localparam int SWW = MW + 4;
  localparam int SGW = MW + GW + 4;

  state_e          state_q;
  and_mode_e       mode_q;
  logic [3:0]      r_q;
  logic [CW-1:0]   ch_q;
  logic            err_q;
  logic [3*MW-1:0] mut_q, mud_q;
  logic [SWW-1:0]  sw_q;
  logic [SGW-1:0]  swg_q;
  logic            out_valid_q, out_nofire_q, out_err_q;
  logic [GW-1:0]   out_g_q;
  logic [CW-1:0]   out_ch_q;

  logic [1:0]       t_term, d_term;
  logic [MW-1:0]    mu_t, mu_d, weight;
  logic [2*MW-1:0]  prod;
  int               g_idx;
  logic [GW-1:0]    g_sel;
  logic [MW+GW-1:0] wg;
  logic [SWW-1:0]   sw_d;
  logic [SGW-1:0]   swg_d;
  logic             div_start, div_done, div_zero;
  logic [GW-1:0]    div_quot;

  always_comb begin
    t_term = rule_t_term(r_q);
    d_term = rule_d_term(r_q);
    mu_t   = mut_q[t_term*MW +: MW];
    mu_d   = mud_q[d_term*MW +: MW];
    prod   = {{MW{1'b0}}, mu_t} * {{MW{1'b0}}, mu_d};
    if (mode_q == AND_PROD) weight = MW'(prod >> MW);
    else                    weight = (mu_t < mu_d) ? mu_t : mu_d;
    g_idx  = err_q ? 0 : (int'(ch_q) * N_RULES + int'(r_q));
    g_sel  = err_q ? '0 : g_tab[g_idx*GW +: GW];
    wg     = {{GW{1'b0}}, weight} * {{MW{1'b0}}, g_sel};
    sw_d   = sw_q + SWW'(weight);
    swg_d  = swg_q + SGW'(wg);
  end

  // Last MAC cycle hands the final sums straight to the divider.
  assign div_start = (state_q == ST_MAC) && (r_q == 4'(N_RULES - 1));

  fuzzy_div_seq #(
    .NW (SGW),
    .DW (SWW),
    .QW (GW)
  ) u_div (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_i    (div_start),
    .dividend_i (swg_d),
    .divisor_i  (sw_d),
    .done_o     (div_done),
    .quot_o     (div_quot),
    .zero_o     (div_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= AND_MIN;
      r_q          <= '0;
      ch_q         <= '0;
      err_q        <= 1'b0;
      mut_q        <= '0;
      mud_q        <= '0;
      sw_q         <= '0;
      swg_q        <= '0;
      out_valid_q  <= 1'b0;
      out_nofire_q <= 1'b0;
      out_err_q    <= 1'b0;
      out_g_q      <= '0;
      out_ch_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            ch_q    <= in_ch;
            mut_q   <= in_muT;
            mud_q   <= in_muD;
            mode_q  <= and_mode_e'(in_mode);
            err_q   <= (int'(in_ch) >= N_CH);
            sw_q    <= '0;
            swg_q   <= '0;
            r_q     <= '0;
            state_q <= ST_MAC;
          end
        end
        ST_MAC: begin
          sw_q  <= sw_d;
          swg_q <= swg_d;
          if (div_start) begin
            r_q     <= '0;
            state_q <= ST_DIV;
          end else begin
            r_q <= r_q + 4'd1;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            out_valid_q  <= 1'b1;
            out_g_q      <= div_quot;
            out_nofire_q <= div_zero;
            out_err_q    <= err_q;
            out_ch_q     <= ch_q;
            state_q      <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_g      = out_g_q;
  assign out_nofire = out_nofire_q;
  assign out_err    = out_err_q;

endmodule
`default_nettype wire
